// File: rtl/pc_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_if
// Groups the instruction-memory request/response channel and the decode
// delivery channel of the fetch unit.
//   master : the fetch unit (drives requests and decoded instructions)
//   slave  : memory + decode side (drives ready/response signals)
// Signals:
//   IMemReqValid/IMemReqReady/IMemReqAddr : word fetch request channel
//   IMemRspValid/IMemRspData              : returned instruction word
//   InstrValid/InstrReady/Instr/InstrPC   : FIFO head presented to decode
// ---------------------------------------------------------------------------
interface pc_fetch_unit_if;
  logic        IMemReqValid;
  logic        IMemReqReady;
  logic [63:0] IMemReqAddr;
  logic        IMemRspValid;
  logic [31:0] IMemRspData;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic [63:0] InstrPC;

  modport master (
    output IMemReqValid,
    output IMemReqAddr,
    input  IMemReqReady,
    input  IMemRspValid,
    input  IMemRspData,
    output InstrValid,
    output Instr,
    output InstrPC,
    input  InstrReady
  );

  modport slave (
    input  IMemReqValid,
    input  IMemReqAddr,
    output IMemReqReady,
    output IMemRspValid,
    output IMemRspData,
    input  InstrValid,
    input  Instr,
    input  InstrPC,
    output InstrReady
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Instruction-fetch front end for the LEGv8 datapath. Owns the architectural
// PC, issues one word fetch at a time to instruction memory, buffers returned
// words with their PCs in a small FIFO and presents the head to decode.
// A taken branch (redirect) flushes buffered/in-flight instructions and
// restarts fetch at the (word-aligned) target.
// Ports:
//   i_CLK        : clock, rising edge
//   i_Reset_L    : synchronous active-low reset
//   i_StartPC    : PC loaded every cycle reset is asserted
//   i_Redirect   : taken branch
//   i_RedirectPC : branch target (low two bits ignored)
//   o_FetchPC    : current PC register (next address to request)
//   bus          : memory request/response and decode channels (master)
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic                   i_CLK,
  input  logic                   i_Reset_L,
  input  logic [63:0]            i_StartPC,
  input  logic                   i_Redirect,
  input  logic [63:0]            i_RedirectPC,
  output logic [63:0]            o_FetchPC,
  pc_fetch_unit_if.master        bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // RUN: idle, WAIT: response owed, DRAIN: response owed but to be dropped
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_live;
  logic [63:0]   r_fetch_pc;
  logic [63:0]   w_fetch_pc_nxt;
  logic [63:0]   r_req_pc;
  logic [63:0]   w_req_pc_nxt;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [31:0]   r_fifo_instr [DEPTH];
  logic [63:0]   r_fifo_pc    [DEPTH];

  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_push;
  logic          w_pop;
  logic          w_instr_valid;
  logic [63:0]   w_redirect_tgt;

  // r_live keeps the request low for the first cycle after reset releases,
  // so the request valid depends on registers only.
  assign w_req_valid    = r_live && (r_state == ST_RUN) && (r_count < DEPTH_C);
  assign w_req_fire     = w_req_valid && bus.IMemReqReady;
  assign w_instr_valid  = (r_count != {CW{1'b0}});
  assign w_pop          = w_instr_valid && bus.InstrReady;
  // A response that coincides with a redirect is dropped, never buffered.
  assign w_push         = (r_state == ST_WAIT) && bus.IMemRspValid && !i_Redirect;
  assign w_redirect_tgt = i_RedirectPC & ~64'd3;

  assign bus.IMemReqValid = w_req_valid;
  assign bus.IMemReqAddr  = r_fetch_pc;
  assign bus.InstrValid   = w_instr_valid;
  assign bus.Instr        = r_fifo_instr[r_rd_ptr];
  assign bus.InstrPC      = r_fifo_pc[r_rd_ptr];
  assign o_FetchPC        = r_fetch_pc;

  // Next-state, PC and FIFO pointer computation
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_pc_nxt   = r_req_pc;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_count_nxt    = r_count;

    case (r_state)
      ST_RUN: begin
        if (w_req_fire) begin
          w_state_nxt = i_Redirect ? ST_DRAIN : ST_WAIT;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (bus.IMemRspValid) begin
          w_state_nxt = ST_RUN;
        end else if (i_Redirect) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (bus.IMemRspValid) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase

    if (w_req_fire) begin
      w_req_pc_nxt = r_fetch_pc;
    end else begin
      w_req_pc_nxt = r_req_pc;
    end

    if (i_Redirect) begin
      // Flush: the head pop this cycle completes implicitly by emptying.
      w_fetch_pc_nxt = w_redirect_tgt;
      w_rd_ptr_nxt   = {PW{1'b0}};
      w_wr_ptr_nxt   = {PW{1'b0}};
      w_count_nxt    = {CW{1'b0}};
    end else begin
      if (w_req_fire) begin
        w_fetch_pc_nxt = r_fetch_pc + 64'd4;
      end else begin
        w_fetch_pc_nxt = r_fetch_pc;
      end
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + PW'(1);
      end else begin
        w_wr_ptr_nxt = r_wr_ptr;
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + PW'(1);
      end else begin
        w_rd_ptr_nxt = r_rd_ptr;
      end
      w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // State, PC and FIFO bookkeeping registers
  always_ff @(posedge i_CLK) begin
    if (!i_Reset_L) begin
      r_state    <= ST_RUN;
      r_live     <= 1'b0;
      r_fetch_pc <= i_StartPC;
      r_req_pc   <= 64'd0;
      r_rd_ptr   <= {PW{1'b0}};
      r_wr_ptr   <= {PW{1'b0}};
      r_count    <= {CW{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_live     <= 1'b1;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_pc   <= w_req_pc_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_count    <= w_count_nxt;
    end
  end

  // FIFO storage; contents are only meaningful where count says so
  always_ff @(posedge i_CLK) begin
    if (i_Reset_L && w_push) begin
      r_fifo_instr[r_wr_ptr] <= bus.IMemRspData;
      r_fifo_pc[r_wr_ptr]    <= r_req_pc;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
// Directed scoreboard bench for pc_fetch_unit: stimulus pushes expected
// {Instr, InstrPC} pairs, a monitor pops and compares on every decode pop,
// and a small memory model answers requests with a programmable latency.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_l;
  logic [63:0] start_pc;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [63:0] fetch_pc;

  pc_fetch_unit_if bus();

  pc_fetch_unit #(.DEPTH(2)) dut (
    .i_CLK       (clk),
    .i_Reset_L   (rst_l),
    .i_StartPC   (start_pc),
    .i_Redirect  (redirect),
    .i_RedirectPC(redirect_pc),
    .o_FetchPC   (fetch_pc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc_n = 0;
  logic [95:0] exp_q [$];
  int          pop_times [$];
  int          mem_lat = 1;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [63:0] pend_addr = 64'd0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Memory image: every word carries the low address bits.
  function automatic logic [31:0] word_at(input logic [63:0] a);
    return 32'h8B00_0000 | {8'h00, a[23:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic expect_instr(input logic [63:0] pc);
    exp_q.push_back({word_at(pc), pc});
  endtask

  task automatic do_reset(input logic [63:0] pc);
    rst_l           = 1'b0;
    start_pc        = pc;
    redirect        = 1'b0;
    bus.InstrReady  = 1'b0;
    cycles(2);
  endtask

  // Wait until the scoreboard empties, then stop decode from taking more.
  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      cyc();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d instructions not delivered, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    bus.InstrReady = 1'b0;
  endtask

  task automatic wait_fire(input string name);
    int n = 0;
    while (!(bus.IMemReqValid && bus.IMemReqReady) && n < 20) begin
      cyc();
      n++;
    end
    total++;
    if (!(bus.IMemReqValid && bus.IMemReqReady)) begin
      bad++;
      $display("FAIL %s: no request accepted within %0d cycles, expected one", name, n);
    end
  endtask

  initial begin
    rst_l            = 1'b0;
    start_pc         = 64'h1000;
    redirect         = 1'b0;
    redirect_pc      = 64'd0;
    bus.IMemReqReady = 1'b1;
    bus.IMemRspValid = 1'b0;
    bus.IMemRspData  = 32'd0;
    bus.InstrReady   = 1'b0;

    fork
      // Memory model: one response per accepted request after mem_lat cycles.
      forever begin
        @(negedge clk);
        if (bus.IMemReqValid && bus.IMemReqReady) begin
          pend      = 1'b1;
          pend_cnt  = mem_lat;
          pend_addr = bus.IMemReqAddr;
        end
        if (!rst_l) pend = 1'b0;
        @(posedge clk);
        #1;
        bus.IMemRspValid = 1'b0;
        if (pend) begin
          if (pend_cnt <= 1) begin
            bus.IMemRspValid = 1'b1;
            bus.IMemRspData  = word_at(pend_addr);
            pend             = 1'b0;
          end else begin
            pend_cnt--;
          end
        end
      end
      // Scoreboard monitor: compare every instruction decode accepts.
      forever begin
        @(negedge clk);
        if (bus.InstrValid && bus.InstrReady) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got pc %h instr %h, expected none", bus.InstrPC, bus.Instr);
          end else begin
            logic [95:0] e;
            e = exp_q.pop_front();
            if ({bus.Instr, bus.InstrPC} !== e) begin
              bad++;
              $display("FAIL sb_instr: got instr %h pc %h expected instr %h pc %h",
                       bus.Instr, bus.InstrPC, e[95:64], e[63:0]);
            end
          end
          pop_times.push_back(cyc_n);
        end
      end
    join_none

    // 1) Sequential fetch from 0x1000, one instruction per two cycles
    do_reset(64'h1000);
    check("rst_req_valid", 64'(bus.IMemReqValid), 64'd0);
    check("rst_instr_valid", 64'(bus.InstrValid), 64'd0);
    check("rst_fetch_pc", fetch_pc, 64'h1000);
    rst_l = 1'b1;
    bus.InstrReady = 1'b1;
    pop_times.delete();
    expect_instr(64'h1000);
    expect_instr(64'h1004);
    expect_instr(64'h1008);
    check("pre_release_req_valid", 64'(bus.IMemReqValid), 64'd0);
    cyc();
    check("first_req_valid", 64'(bus.IMemReqValid), 64'd1);
    check("first_req_addr", bus.IMemReqAddr, 64'h1000);
    wait_drain("t1_drain");
    check("t1_pop_count", 64'(pop_times.size()), 64'd3);
    if (pop_times.size() >= 3) begin
      check("t1_gap_a", 64'(pop_times[1] - pop_times[0]), 64'd2);
      check("t1_gap_b", 64'(pop_times[2] - pop_times[1]), 64'd2);
    end

    // 2) Decode stalled: FIFO fills, fetch stops at 0x1008, then resumes
    do_reset(64'h1000);
    rst_l = 1'b1;
    cycles(10);
    check("full_req_valid", 64'(bus.IMemReqValid), 64'd0);
    check("full_fetch_pc", fetch_pc, 64'h1008);
    check("full_instr_valid", 64'(bus.InstrValid), 64'd1);
    check("full_head_pc", bus.InstrPC, 64'h1000);
    check("full_head_instr", 64'(bus.Instr), 64'(word_at(64'h1000)));
    expect_instr(64'h1000);
    expect_instr(64'h1004);
    expect_instr(64'h1008);
    bus.InstrReady = 1'b1;
    wait_drain("t2_drain");

    // 3) Redirect while waiting on a slow response: response dropped
    do_reset(64'h1000);
    mem_lat = 3;
    rst_l = 1'b1;
    bus.InstrReady = 1'b1;
    wait_fire("t3_fire");
    cyc();
    redirect    = 1'b1;
    redirect_pc = 64'h2000;
    cyc();
    redirect = 1'b0;
    mem_lat  = 1;
    check("t3_fetch_pc", fetch_pc, 64'h2000);
    check("t3_drain_req_valid", 64'(bus.IMemReqValid), 64'd0);
    check("t3_fifo_empty", 64'(bus.InstrValid), 64'd0);
    cyc();
    check("t3_drain_req_valid2", 64'(bus.IMemReqValid), 64'd0);
    cyc();
    check("t3_req_valid", 64'(bus.IMemReqValid), 64'd1);
    check("t3_req_addr", bus.IMemReqAddr, 64'h2000);
    check("t3_fifo_empty2", 64'(bus.InstrValid), 64'd0);
    expect_instr(64'h2000);
    wait_drain("t3_drain");

    // 4) Redirect to unaligned 0x3003 while the request is not accepted
    do_reset(64'h1000);
    bus.IMemReqReady = 1'b0;
    rst_l = 1'b1;
    bus.InstrReady = 1'b1;
    cyc();
    check("t4_stalled_addr", bus.IMemReqAddr, 64'h1000);
    redirect    = 1'b1;
    redirect_pc = 64'h3003;
    cyc();
    redirect = 1'b0;
    check("t4_req_valid", 64'(bus.IMemReqValid), 64'd1);
    check("t4_req_addr", bus.IMemReqAddr, 64'h3000);
    check("t4_fetch_pc", fetch_pc, 64'h3000);
    bus.IMemReqReady = 1'b1;
    expect_instr(64'h3000);
    wait_drain("t4_drain");

    // 5) PC wraps from the top of the address space to zero
    do_reset(64'hFFFF_FFFF_FFFF_FFFC);
    rst_l = 1'b1;
    bus.InstrReady = 1'b1;
    expect_instr(64'hFFFF_FFFF_FFFF_FFFC);
    expect_instr(64'h0);
    wait_fire("t5_fire");
    cyc();
    check("t5_wrap_fetch_pc", fetch_pc, 64'h0);
    wait_drain("t5_drain");

    // 6) Reset with two buffered instructions, restart at 0x4000
    do_reset(64'h1000);
    rst_l = 1'b1;
    cycles(10);
    check("t6_buffered", 64'(bus.InstrValid), 64'd1);
    rst_l    = 1'b0;
    start_pc = 64'h4000;
    cyc();
    check("t6_instr_valid", 64'(bus.InstrValid), 64'd0);
    check("t6_req_valid", 64'(bus.IMemReqValid), 64'd0);
    check("t6_fetch_pc", fetch_pc, 64'h4000);
    cyc();
    rst_l = 1'b1;
    bus.InstrReady = 1'b1;
    expect_instr(64'h4000);
    wait_drain("t6_drain");

    cycles(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch front end for the LEGv8 datapath: owns the architectural program counter and consumes the branch target produced by the next-PC logic. Issues word fetches to instruction memory over a valid/ready request channel, buffers returned instructions with their PCs in a small FIFO, and presents them to decode. A taken branch (`Redirect`) flushes buffered and in-flight instructions and restarts fetch at the target.

## Interface
- `DEPTH`, 2, instruction FIFO entries; power of two, ≥2
- `CLK` in 1: the single clock; all state updates on rising edge
- `Reset_L` in 1: synchronous, active-low reset
- `StartPC` in 64: PC loaded on every cycle `Reset_L`=0
- `FetchPC` out 64: current PC register (next address to request)
- `IMemReqValid` out 1: fetch request valid
- `IMemReqReady` in 1: memory accepts request
- `IMemReqAddr` out 64: request address; always equals `FetchPC`
- `IMemRspValid` in 1: instruction word returned; no backpressure
- `IMemRspData` in 32: instruction word
- `Redirect` in 1: taken branch/unconditional branch
- `RedirectPC` in 64: branch target (`CurrentPC + SignExtImm64*4`)
- `InstrValid` out 1: `Instr`/`InstrPC` valid to decode
- `InstrReady` in 1: decode accepts
- `Instr` out 32, `InstrPC` out 64: FIFO head word and its fetch address

## Operation
- Reset (`Reset_L`=0 at edge): `FetchPC`←`StartPC`, state←RUN, FIFO count←0, `IMemReqValid`=0, `InstrValid`=0 (outputs valid-low during and one cycle after reset edge since driven from state/count; `IMemReqValid` first rises the cycle after reset deasserts).
- States: RUN (no request outstanding), WAIT (one accepted request outstanding, response expected), DRAIN (one outstanding request whose response must be discarded).
- `IMemReqValid` = (state==RUN) && (count < DEPTH); decoded from registers only, never from inputs. At most one request outstanding.
- RUN: on `IMemReqValid && IMemReqReady` latch ReqPC←`FetchPC`, `FetchPC`←`FetchPC`+4 (mod 2^64), →WAIT.
- WAIT: on `IMemRspValid` push {`IMemRspData`, ReqPC} into FIFO, →RUN. Space is guaranteed by issue rule.
- DRAIN: on `IMemRspValid` discard data, →RUN.
- `IMemRspValid` in RUN: protocol violation, ignored, no state change.
- Decode side: `InstrValid` = count≠0; pop on `InstrValid && InstrReady`. Simultaneous push and pop: count unchanged, order preserved.
- Redirect (highest priority, overrides all other updates except reset):
  - FIFO flushed (count←0); a pop in the same cycle still completes.
  - `FetchPC`←{`RedirectPC`[63:2], 2'b00}.
  - RUN with request accepted same cycle, or WAIT without response this cycle → DRAIN.
  - WAIT with `IMemRspValid` same cycle → response discarded, →RUN.
  - RUN with `IMemReqValid && !IMemReqReady` → request withdrawn; next cycle re-presented at new address. Memory tolerates withdrawal only in this case.
  - DRAIN → stays DRAIN unless response arrives same cycle (then RUN).
- Reset mid-operation: any outstanding response arriving after reset is a bench error; not handled.

## Timing
- Request-to-issue: `IMemReqValid` asserted first cycle after reset release (`IMemReqAddr`=`StartPC`).
- With 1-cycle memory: request accepted cycle N, response N+1, `InstrValid` N+2. Peak throughput one instruction per 2 cycles.
- Redirect at cycle N: `IMemReqAddr`=target earliest N+1 (RUN) or cycle after drained response.
- FIFO full (count==DEPTH): `IMemReqValid` stays 0 until a pop.
- `InstrValid`, `Instr`, `InstrPC` registered; stable while `InstrValid && !InstrReady`.

## Test plan
- Reset with `StartPC`=0x1000, memory always ready, 1-cycle latency, decode always ready → `InstrPC` sequence 0x1000, 0x1004, 0x1008, one per 2 cycles, words match memory image.
- Decode stalled (`InstrReady`=0) → after 2 fetches `IMemReqValid`=0, `FetchPC`=0x1008; release → 0x1000, 0x1004 pop in order, fetch resumes at 0x1008.
- `Redirect` with `RedirectPC`=0x2000 in WAIT, response arriving 3 cycles later → response discarded, FIFO empty, next request addr 0x2000, first `InstrPC`=0x2000.
- `Redirect` while `IMemReqValid`=1, `IMemReqReady`=0 → request withdrawn, next cycle `IMemReqAddr`=target; no stale instruction delivered.
- `RedirectPC`=0x3003 → `FetchPC`=0x3000; `FetchPC`=0xFFFF_FFFF_FFFF_FFFC sequential fetch → wraps to 0x0.
- Assert `Reset_L`=0 with 2 buffered instructions, `StartPC`=0x4000 → next cycle `InstrValid`=0, `IMemReqValid`=0, `FetchPC`=0x4000; after release first `InstrPC`=0x4000.
